// File: rtl/spi_slave_pkg.sv
// State encoding and command constants shared by the SPI slave and its bench-facing top.
package spi_slave_pkg;

  localparam int SPI_CMD_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADDR = 3'd3,
    ST_READ_WAIT = 3'd4,
    ST_READ_DATA = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam logic [SPI_CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [SPI_CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [SPI_CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [SPI_CMD_W-1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shifter.sv
// Generic shift register: serial in at the LSB, parallel load, synchronous clear.
// Priority is clear, then load, then shift.
module spi_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave taking {2-bit cmd, DATA_W payload} frames MSB-first; cmd 2'b11 returns a payload on MISO.
// Define SPI_SLAVE_BURST_EN to accept back-to-back frames within one SS_n assertion.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int CMD_W = SPI_CMD_W,
  localparam int FRAME_W = CMD_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  input  logic               tx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  output logic               MISO,
  output logic               rx_valid,
  output logic [FRAME_W-1:0] rx_data,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_RX_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_TX_BIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef SPI_SLAVE_BURST_EN
  localparam state_t FRAME_END_ST = ST_CHK_CMD;
`else
  localparam state_t FRAME_END_ST = ST_DONE;
`endif

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 rx_valid_nxt;
  logic                 frame_err_nxt;
  logic                 rx_capture;
  logic                 rx_shift;
  logic                 shift_clr;
  logic                 tx_load;
  logic                 tx_shift;
  logic [FRAME_W-2:0]   rx_q;
  logic [DATA_W-1:0]    tx_q;
  logic                 tx_tail_unused;

  // Bit 0 is taken straight from MOSI on the capture edge, so the rx register holds only FRAME_W-1 bits.
  spi_shifter #(.W(FRAME_W - 1)) u_rx_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (shift_clr),
    .load     (1'b0),
    .load_dat ('0),
    .shift    (rx_shift),
    .sin      (MOSI),
    .q        (rx_q)
  );

  // MISO is the tx register MSB; zeros shift in behind the payload, so it idles low.
  spi_shifter #(.W(DATA_W)) u_tx_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (shift_clr),
    .load     (tx_load),
    .load_dat (tx_data),
    .shift    (tx_shift),
    .sin      (1'b0),
    .q        (tx_q)
  );

  assign MISO           = tx_q[DATA_W-1];
  assign tx_tail_unused = |tx_q[DATA_W-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    rx_capture    = 1'b0;
    rx_shift      = 1'b0;
    shift_clr     = 1'b0;
    tx_load       = 1'b0;
    tx_shift      = 1'b0;
    if (SS_n) begin
      state_nxt     = ST_IDLE;
      cnt_nxt       = '0;
      shift_clr     = 1'b1;
      frame_err_nxt = (cnt != '0) || (state == ST_READ_WAIT) || (state == ST_READ_DATA);
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_CHK_CMD;
        ST_CHK_CMD: begin
          rx_shift  = 1'b1;
          cnt_nxt   = CNT_ONE;
          state_nxt = MOSI ? ST_READ_ADDR : ST_WRITE;
        end
        ST_WRITE, ST_READ_ADDR: begin
          if (cnt == LAST_RX_BIT) begin
            rx_capture   = 1'b1;
            rx_valid_nxt = 1'b1;
            cnt_nxt      = '0;
            case (rx_q[FRAME_W-2 -: CMD_W])
              CMD_WR_ADDR, CMD_WR_DATA: state_nxt = FRAME_END_ST;
              CMD_RD_ADDR:              state_nxt = ST_DONE;
              CMD_RD_DATA:              state_nxt = ST_READ_WAIT;
              default:                  state_nxt = ST_DONE;
            endcase
          end else begin
            rx_shift = 1'b1;
            cnt_nxt  = cnt + CNT_ONE;
          end
        end
        ST_READ_WAIT: begin
          if (tx_valid) begin
            tx_load   = 1'b1;
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_READ_DATA;
          end
        end
        ST_READ_DATA: begin
          tx_shift = 1'b1;
          if (cnt == LAST_TX_BIT) begin
            cnt_nxt   = '0;
            state_nxt = FRAME_END_ST;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      cnt       <= cnt_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
      if (rx_capture) begin
        rx_data <= {rx_q, MOSI};
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param (DATA_W=8): directed and random frames against a frame-level timing model.
module tb_spi_slave_param;

  localparam int DW = 8;
  localparam int FW = DW + 2;
`ifdef SPI_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          SS_n;
  logic          MOSI;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          MISO;
  logic          rx_valid;
  logic [FW-1:0] rx_data;
  logic          frame_err;

  int            n_chk  = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  logic [FW-1:0] exp_rx = '0;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .MISO      (MISO),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step s = observation #1 after the s-th rising edge since SS_n fell. Bit k of the frame is
  // sampled on edge 11-k, the completed frame shows at step 11, and tx_valid raised after step
  // w0 loads the payload so its bits appear on MISO at steps w0+1 .. w0+8.
  // SS_n is raised after step 'a' (abort point or natural end); rst_step pulses reset instead.
  task automatic run_frame(input logic [FW-1:0] frame, input logic [DW-1:0] txd,
                           input int w, input int abort_at, input int rst_step);
    logic [1:0]    cmd;
    logic [FW-1:0] f2;
    logic          exp_miso;
    bit            err_exp;
    bit            burst2;
    int            w0;
    int            a;
    cmd = frame[FW-1:FW-2];
    f2  = {1'b0, 9'($urandom)};
    w0  = 11 + w;
    if (abort_at != 0) a = abort_at;
    else a = (cmd == 2'b11) ? w0 + 9 : 21;
    err_exp = (a >= 2 && a <= 10) || (cmd == 2'b11 && a >= 11 && a <= w0 + 8);
    burst2  = BURST && !cmd[1] && a >= 21;
    SS_n     = 1'b0;
    MOSI     = 1'($urandom);
    tx_valid = (cmd == 2'b11) ? 1'b0 : 1'($urandom);
    tx_data  = DW'($urandom);
    for (int s = 1; s <= a + 2; s++) begin
      @(posedge clk);
      #1;
      if (s == 11 && a >= 11) exp_rx = frame;
      if (s == 21 && burst2) exp_rx = f2;
      exp_miso = (cmd == 2'b11 && s > w0 && s <= w0 + 8 && s <= a) ? txd[DW - 1 - (s - w0 - 1)] : 1'b0;
      chk("rx_valid", 32'(rx_valid), 32'((s == 11 && a >= 11) || (s == 21 && burst2)));
      chk("rx_data", 32'(rx_data), 32'(exp_rx));
      chk("frame_err", 32'(frame_err), 32'(s == a + 1 && err_exp));
      chk("miso", 32'(MISO), 32'(exp_miso));
      if (s == rst_step) begin
        #2 rst_n = 1'b0;
        #1;
        exp_rx = '0;
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      MOSI     = (s <= 10) ? frame[10 - s] : ((s <= 20) ? f2[20 - s] : 1'($urandom));
      tx_valid = (cmd == 2'b11) ? (s >= w0) : 1'($urandom);
      tx_data  = (s == w0) ? txd : DW'($urandom);
      if (s >= a) SS_n = 1'b1;
    end
  endtask

  initial begin
    logic [FW-1:0] fr;
    int            w;
    int            ab;
    int            mode;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_frame_err", 32'(frame_err), 32'd0);

    run_frame(10'h0A5, 8'h00, 0, 0, 0);
    run_frame(10'h301, 8'hC3, 3, 0, 0);
    run_frame(10'h210, 8'h5A, 0, 0, 0);
    run_frame(10'h15A, 8'h00, 0, 6, 0);
    run_frame(10'h15A, 8'h00, 0, 0, 0);
    run_frame(10'h3FF, 8'h81, 1, 13, 0);
    run_frame(10'h3AA, 8'h96, 0, 15, 0);
    run_frame(10'h0FF, 8'h00, 0, 1, 0);

    run_frame(10'h37E, 8'hA5, 1, 0, 15);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_frame_err", 32'(frame_err), 32'd0);
      chk("post_rst_miso", 32'(MISO), 32'd0);
    end
    run_frame(10'h1C3, 8'h00, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      fr   = FW'($urandom);
      w    = $urandom_range(0, 4);
      mode = $urandom_range(0, 3);
      ab   = 0;
      if (mode == 2) ab = $urandom_range(1, 10);
      if (mode == 3) ab = (fr[FW-1:FW-2] == 2'b11) ? $urandom_range(11, 19 + w) : $urandom_range(1, 10);
      run_frame(fr, DW'($urandom), w, ab, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range 4..32.
REQ-002 Parameter CMD_W, fixed 2, command-prefix width; FRAME_W = CMD_W + DATA_W.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SS_n  input  1  slave select, active-low; frame boundary.
REQ-006 MOSI  input  1  serial data in, MSB first, one bit per clk while SS_n low.
REQ-007 tx_valid  input  1  read payload available on tx_data.
REQ-008 tx_data  input  DATA_W  read payload to shift out.
REQ-009 MISO  output  1  registered serial data out, MSB first.
REQ-010 rx_valid  output  1  one-cycle pulse: rx_data holds a complete frame.
REQ-011 rx_data  output  FRAME_W  last complete received frame; {cmd, payload}.
REQ-012 frame_err  output  1  one-cycle pulse: SS_n deasserted mid-frame.

Function
REQ-013 States: IDLE, CHK_CMD, WRITE, READ_ADDR, READ_WAIT, READ_DATA, DONE.
REQ-014 IDLE -> CHK_CMD when SS_n low; otherwise stay in IDLE.
REQ-015 CHK_CMD samples MOSI as frame bit FRAME_W-1; MOSI=0 -> WRITE, MOSI=1 -> READ_ADDR.
REQ-016 WRITE/READ_ADDR shift MOSI into the frame register, one bit per clk, until FRAME_W bits are captured.
REQ-017 On the edge capturing bit 0: rx_data <= frame; rx_valid high for exactly the following cycle; bit counter cleared.
REQ-018 Frame cmd 2'b00 or 2'b01 completes in WRITE -> DONE; cmd 2'b10 completes in READ_ADDR -> DONE; cmd 2'b11 completes in READ_ADDR -> READ_WAIT.
REQ-019 READ_WAIT holds MISO=0 until tx_valid is sampled high; on that edge it loads tx_data, sets MISO <= tx_data[DATA_W-1], and moves to READ_DATA.
REQ-020 READ_DATA drives the remaining DATA_W-1 bits MSB-first, one per clk, then MISO <= 0 and moves to DONE.
REQ-021 DONE ignores MOSI, holds MISO=0, and remains until SS_n is high.
REQ-022 SS_n high in any state -> IDLE on the next edge; bit counter and shift state are cleared.
REQ-023 frame_err pulses for one cycle when SS_n rises while the bit counter is nonzero or the state is READ_WAIT/READ_DATA; rx_valid does not assert for the aborted frame.
REQ-024 rx_data holds its value between frames and changes only per REQ-017.
REQ-025 The bit counter is $clog2(FRAME_W+1) bits wide and never exceeds FRAME_W.

Reset
REQ-026 rst_n low asynchronously forces state=IDLE, counter=0, MISO=0, rx_valid=0, frame_err=0, rx_data=0, and the tx shift register to 0.
REQ-027 Reset deassertion mid-frame: operation resumes in IDLE; a new frame requires SS_n low, with no frame_err.

Configuration
REQ-028 Macro SPI_SLAVE_BURST_EN: when defined, a completed write frame or completed READ_DATA with SS_n still low goes to CHK_CMD instead of DONE, allowing back-to-back frames in one select.
REQ-029 Without SPI_SLAVE_BURST_EN, exactly one frame (plus read payload) is accepted per SS_n assertion, per REQ-018..021.

Structure
REQ-030 Package spi_slave_pkg holds the state enum encoding and the command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
REQ-031 One sub-module, spi_shifter (parametrised width, serial-in/serial-out, parallel load), serves both the rx frame register and the tx shift register.

Verification (DATA_W=8)
REQ-032 SS_n low, MOSI 00_1010_0101 over 10 clks -> single rx_valid pulse; rx_data=10'h0A5; MISO stays 0.
REQ-033 Frame 11_0000_0001, then tx_valid=1 with tx_data=8'hC3 three clks later -> MISO serially 1,1,0,0,0,0,1,1 on consecutive clks, then 0.
REQ-034 Frame 10_0001_0000 -> rx_valid pulse with rx_data=10'h210; DONE reached; tx_valid ignored; MISO=0.
REQ-035 SS_n raised after 5 bits -> frame_err pulses once; no rx_valid; next full frame is received correctly.
REQ-036 rst_n pulsed low during READ_DATA -> MISO=0 and rx_valid=0 immediately; IDLE after release.
REQ-037 With SPI_SLAVE_BURST_EN: two write frames 10'h0A5 and 10'h15A in one select -> two rx_valid pulses, 10 clks apart, with matching rx_data.
